// File: rtl/lcd_pkg.sv
// Shared constants and types for the HD44780 16x2 frame controller.
// Holds the LCD command bytes, the top-level state encoding, the write
// phase enum and two small command helpers.
package lcd_pkg;

    // HD44780 command bytes
    localparam logic [7:0] FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] DISP_ON    = 8'h0C;  // display on, cursor off
    localparam logic [7:0] DISP_BLINK = 8'h0D;  // display on, blinking cursor
    localparam logic [7:0] ENTRY      = 8'h06;  // increment address, no shift
    localparam logic [7:0] CLEAR      = 8'h01;  // clear display, home
    localparam logic [7:0] LINE1      = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] LINE2      = 8'hC0;  // DDRAM address 0x40

    // Top-level sequencer states
    typedef logic [2:0] state_t;
    localparam state_t ST_PWR_WAIT = 3'd0;
    localparam state_t ST_INIT     = 3'd1;
    localparam state_t ST_CLR_WAIT = 3'd2;
    localparam state_t ST_L1_ADDR  = 3'd3;
    localparam state_t ST_L1_CHAR  = 3'd4;
    localparam state_t ST_L2_ADDR  = 3'd5;
    localparam state_t ST_L2_CHAR  = 3'd6;
    localparam state_t ST_CUR_ADDR = 3'd7;

    // Phases of one bus write
    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_PULSE = 2'd1,
        PH_HOLD  = 2'd2
    } phase_e;

    // Command issued at each of the four init steps
    function automatic logic [7:0] init_cmd(input logic [1:0] step, input logic blink);
        logic [7:0] cmd;
        case (step)
            2'd0:    cmd = FUNC_SET;
            2'd1:    cmd = blink ? DISP_BLINK : DISP_ON;
            2'd2:    cmd = ENTRY;
            default: cmd = CLEAR;
        endcase
        return cmd;
    endfunction

    // Set-DDRAM-address command for a 0..31 character position
    function automatic logic [7:0] cursor_cmd(input logic [4:0] pos);
        return (pos[4] ? LINE2 : LINE1) | {4'h0, pos[3:0]};
    endfunction

endpackage

// File: rtl/hd44780_frame_ctrl_write_seq.sv
// Three-phase HD44780 bus write engine (SETUP, PULSE, HOLD).
// Handshake: a write is accepted on an en_clk tick when start=1 and busy=0;
// rs_in/data_in are captured on that tick (SETUP). busy stays high through
// SETUP and PULSE and drops in HOLD, so the next write can be accepted on
// the tick that ends HOLD, giving back-to-back writes of exactly 3 ticks.
// done is high during PULSE: the strobe ends on the next en_clk tick.
module hd44780_write_seq
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_clk,
    input  logic       start,
    input  logic       rs_in,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    logic       active_q, active_d;
    phase_e     phase_q, phase_d;
    logic       e_q, e_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;

    assign busy     = active_q && (phase_q != PH_HOLD);
    assign done     = active_q && (phase_q == PH_PULSE);
    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;

    // Phase sequencing; rs/data are only reloaded when a new write starts
    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        e_d      = e_q;
        rs_d     = rs_q;
        data_d   = data_q;
        if (en_clk) begin
            if (!active_q || phase_q == PH_HOLD) begin
                e_d     = 1'b0;
                phase_d = PH_SETUP;
                if (start) begin
                    active_d = 1'b1;
                    rs_d     = rs_in;
                    data_d   = data_in;
                end else begin
                    active_d = 1'b0;
                end
            end else if (phase_q == PH_SETUP) begin
                phase_d = PH_PULSE;
                e_d     = 1'b1;
            end else begin
                phase_d = PH_HOLD;
                e_d     = 1'b0;
            end
        end
    end

    // State and bus registers
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            phase_q  <= PH_SETUP;
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            e_q      <= e_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: rtl/hd44780_frame_ctrl.sv
// HD44780 16x2 frame controller: power-up wait, init commands, then an
// endless refresh of both lines from the upstream character mux.
// Optional feature macro: LCD_CURSOR_EN adds a cursor[4:0] input, a
// blinking cursor in init, and a cursor-address command after line 2.
// All steps advance only on clk edges where en_clk=1.
module hd44780_frame_ctrl
    import lcd_pkg::*;
#(
    parameter int PWR_TICKS = 20,   // >= 1
    parameter int CLR_TICKS = 2
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_clk,
    input  logic [7:0] data_char,
`ifdef LCD_CURSOR_EN
    input  logic [4:0] cursor,
`endif
    output logic [4:0] index_char,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    localparam int PWR_W = (PWR_TICKS > 0) ? $clog2(PWR_TICKS + 1) : 1;
    localparam int CLR_W = (CLR_TICKS > 0) ? $clog2(CLR_TICKS + 1) : 1;
    localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWR_TICKS - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_TICKS - 1);
`ifdef LCD_CURSOR_EN
    localparam logic BLINK = 1'b1;
`else
    localparam logic BLINK = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [4:0]       index_q, index_d;

    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       seq_busy;
    logic       seq_done;
    logic       accept;

    // A pending request launches on any tick where the write engine is free
    assign accept     = en_clk && !seq_busy;
    assign lcd_rw     = 1'b0;
    assign index_char = index_q;

    hd44780_write_seq u_write_seq (
        .clk      (clk),
        .rst      (rst),
        .en_clk   (en_clk),
        .start    (req_valid),
        .rs_in    (req_rs),
        .data_in  (req_data),
        .busy     (seq_busy),
        .done     (seq_done),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data)
    );

    // Command sequencing: each state requests one write and moves on when it launches
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        pwr_cnt_d = pwr_cnt_q;
        clr_cnt_d = clr_cnt_q;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_data  = 8'h00;
        case (state_q)
            ST_PWR_WAIT: begin
                if (en_clk) begin
                    if (pwr_cnt_q == PWR_LAST) begin
                        state_d   = ST_INIT;
                        pwr_cnt_d = '0;
                    end else begin
                        pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
                    end
                end
            end
            ST_INIT: begin
                req_valid = 1'b1;
                req_data  = init_cmd(step_q, BLINK);
                if (accept) begin
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        state_d = (CLR_TICKS == 0) ? ST_L1_ADDR : ST_CLR_WAIT;
                    end
                end
            end
            ST_CLR_WAIT: begin
                // Counting starts once the clear write has reached HOLD
                if (accept) begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_d   = ST_L1_ADDR;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + CLR_W'(1);
                    end
                end
            end
            ST_L1_ADDR: begin
                req_valid = 1'b1;
                req_data  = LINE1;
                if (accept) state_d = ST_L1_CHAR;
            end
            ST_L1_CHAR: begin
                req_valid = 1'b1;
                req_rs    = 1'b1;
                req_data  = data_char;
                if (accept && index_q[3:0] == 4'hF) state_d = ST_L2_ADDR;
            end
            ST_L2_ADDR: begin
                req_valid = 1'b1;
                req_data  = LINE2;
                if (accept) state_d = ST_L2_CHAR;
            end
            ST_L2_CHAR: begin
                req_valid = 1'b1;
                req_rs    = 1'b1;
                req_data  = data_char;
                if (accept && index_q[3:0] == 4'hF) begin
`ifdef LCD_CURSOR_EN
                    state_d = ST_CUR_ADDR;
`else
                    state_d = ST_L1_ADDR;
`endif
                end
            end
`ifdef LCD_CURSOR_EN
            ST_CUR_ADDR: begin
                req_valid = 1'b1;
                req_data  = cursor_cmd(cursor);
                if (accept) state_d = ST_L1_ADDR;
            end
`endif
            default: begin
                state_d = ST_PWR_WAIT;
            end
        endcase
    end

    // Character index advances as a data write leaves PULSE, so it changes in HOLD
    always_comb begin
        index_d = index_q;
        if (en_clk && seq_done && lcd_rs) begin
            index_d = index_q + 5'd1;
        end
    end

    // Sequencer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PWR_WAIT;
            step_q    <= 2'd0;
            pwr_cnt_q <= '0;
            clr_cnt_q <= '0;
            index_q   <= 5'd0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            pwr_cnt_q <= pwr_cnt_d;
            clr_cnt_q <= clr_cnt_d;
            index_q   <= index_d;
        end
    end

endmodule

// File: tb/tb_hd44780_frame_ctrl.sv
// Self-checking bench for hd44780_frame_ctrl. The reference model is the
// list of bus writes the display should see (init bytes, then line address
// + 16 characters per line), pushed into exp_q; a monitor pops one entry
// per rising lcd_e. Build with LCD_CURSOR_EN to cover the cursor variant.
module tb_hd44780_frame_ctrl;

    localparam int PWR_TICKS = 20;
    localparam int CLR_TICKS = 2;
`ifdef LCD_CURSOR_EN
    localparam int WPF = 35;
    localparam logic [7:0] DISP_EXP = 8'h0D;
`else
    localparam int WPF = 34;
    localparam logic [7:0] DISP_EXP = 8'h0C;
`endif
    localparam int FRAME_TICKS = 3 * WPF;

    logic       clk;
    logic       rst;
    logic       en_clk;
    logic [7:0] data_char;
    logic [4:0] index_char;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic [7:0] mem [32];
`ifdef LCD_CURSOR_EN
    logic [4:0] cursor;
`endif

    logic [8:0] exp_q[$];
    int         rise_cyc[$];
    int         checks;
    int         errors;
    int         pops;
    int         cyc;
    int         en_mode;    // 0 always, 1 every 4th clk, 2 random, 3 held low
    int         width_exp;  // expected lcd_e high clks, 0 = not checked

    // Upstream character mux model
    assign data_char = mem[index_char];

    hd44780_frame_ctrl #(
        .PWR_TICKS (PWR_TICKS),
        .CLR_TICKS (CLR_TICKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_clk     (en_clk),
        .data_char  (data_char),
`ifdef LCD_CURSOR_EN
        .cursor     (cursor),
`endif
        .index_char (index_char),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .lcd_data   (lcd_data)
    );

    // Clock and cycle counter (counts clk edges since reset release)
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            if (rst) cyc = 0;
            else     cyc = cyc + 1;
        end
    end

    // en_clk pacing driver
    initial begin
        int ph;
        ph = 0;
        en_clk = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (en_mode)
                0: en_clk = 1'b1;
                1: begin
                    ph = (ph + 1) % 4;
                    en_clk = (ph == 0);
                end
                2: en_clk = ($urandom_range(0, 2) == 0);
                default: en_clk = 1'b0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected write stream from reset: init, then whole frames
    task automatic push_stream(input int frames);
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, DISP_EXP});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
        for (int f = 0; f < frames; f++) begin
            for (int line = 0; line < 2; line++) begin
                exp_q.push_back({1'b0, (line == 0) ? 8'h80 : 8'hC0});
                for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, mem[line * 16 + c]});
            end
`ifdef LCD_CURSOR_EN
            if (cursor >= 5'd16) exp_q.push_back({1'b0, 8'hC0 + 8'(cursor - 5'd16)});
            else                 exp_q.push_back({1'b0, 8'h80 + 8'(cursor)});
`endif
        end
    endtask

    // Apply reset, check outputs one edge later, reload the model, release
    task automatic do_reset(input int mem_mode);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_lcd_e", lcd_e, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_lcd_data", lcd_data, 0);
        check("rst_index", index_char, 0);
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            if (mem_mode == 1) mem[i] = 8'h40 + 8'(i);
            else               mem[i] = 8'($urandom_range(0, 255));
        end
        if (mem_mode == 2) begin
            mem[0]  = 8'h00;
            mem[31] = 8'hFF;
        end
        push_stream(3);
        pops = 0;
        rise_cyc.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (pops < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, pops >= target, 1);
    endtask

    // Scoreboard monitor: one expected entry per lcd_e rise
    initial begin : monitor
        logic [8:0] cap;
        logic [8:0] exp_w;
        logic       prev_e;
        int         hi_cnt;
        cap = '0;
        prev_e = 1'b0;
        hi_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_e = 1'b0;
                hi_cnt = 0;
            end else begin
                if (lcd_e && !prev_e) begin
                    cap = {lcd_rs, lcd_data};
                    rise_cyc.push_back(cyc);
                    pops = pops + 1;
                    check("lcd_rw", lcd_rw, 0);
                    if (exp_q.size() == 0) begin
                        checks = checks + 1;
                        errors = errors + 1;
                        $display("FAIL sb_underflow: got write 0x%0h, expected none", cap);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("sb_write", cap, exp_w);
                    end
                    hi_cnt = 1;
                end else if (lcd_e) begin
                    hi_cnt = hi_cnt + 1;
                end else if (prev_e) begin
                    if (width_exp != 0) check("e_width", hi_cnt, width_exp);
                    check("bus_hold", {lcd_rs, lcd_data}, cap);
                end
                prev_e = lcd_e;
            end
        end
    end

    // Main sequence
    initial begin
        logic [8:0] held;
        int n;
        checks = 0;
        errors = 0;
        pops = 0;
        rst = 1'b1;
        en_mode = 0;
        width_exp = 1;
`ifdef LCD_CURSOR_EN
        cursor = 5'd18;
`endif
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;

        // Power-up timing, init gap and frame period with en_clk always high
        repeat (2) @(posedge clk);
        do_reset(0);
        wait_pops(4 + 2 * WPF + 1, 1500, "run_always_en");
        if (rise_cyc.size() > 4 + WPF) begin
            check("pwr_wait_first_e", rise_cyc[0], PWR_TICKS + 2);
            check("clear_gap", rise_cyc[4] - rise_cyc[3], 3 + CLR_TICKS);
            check("frame_ticks", rise_cyc[4 + WPF] - rise_cyc[4], FRAME_TICKS);
        end

        // Ramp data 0x40+index with en_clk every 4th clk
        en_mode = 1;
        width_exp = 4;
        do_reset(1);
        wait_pops(4 + WPF + 1, 2500, "run_quarter_en");

        // Freeze en_clk for 50 clk during a character PULSE
        n = 0;
        while (!(lcd_e && lcd_rs) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("pause_pulse_found", lcd_e && lcd_rs, 1);
        width_exp = 0;
        held = {lcd_rs, lcd_data};
        @(posedge clk);
        #1;
        en_mode = 3;
        repeat (50) begin
            @(negedge clk);
            check("pause_e", lcd_e, 1);
            check("pause_bus", {lcd_rs, lcd_data}, held);
        end
        @(posedge clk);
        #1;
        en_mode = 1;
        n = 0;
        while (lcd_e && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pause_release", lcd_e, 0);
        @(negedge clk);
        width_exp = 4;
        n = pops;
        wait_pops(n + 20, 1500, "run_after_pause");

        // Reset in the middle of the index 7 write, then random pacing and data
        n = 0;
        while (!(lcd_e && index_char == 5'd7) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idx7_write_found", lcd_e && index_char == 5'd7, 1);
        en_mode = 2;
        width_exp = 0;
        do_reset(2);
        wait_pops(4 + WPF + 1, 3000, "run_random_en");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
